// File: rtl/mvu_apb_csr_if.sv
// APB completer bus bundle for the MVU CSR block.
interface mvu_apb_csr_if;
   logic        psel;
   logic        penable;
   logic        pwrite;
   logic [14:0] paddr;
   logic [31:0] pwdata;
   logic [3:0]  pstrb;
   logic [31:0] prdata;
   logic        pready;
   logic        pslverr;

   modport master (
      output psel, penable, pwrite, paddr, pwdata, pstrb,
      input  prdata, pready, pslverr
   );

   modport slave (
      input  psel, penable, pwrite, paddr, pwdata, pstrb,
      output prdata, pready, pslverr
   );
endinterface

// File: rtl/mvu_apb_csr.sv
// MVU control/status register block behind an APB completer.
// Each transfer runs IDLE -> WAIT -> RESP; the request is latched on acceptance
// so a master that drops psel early still gets its transfer completed.
module mvu_apb_csr #(
   parameter int unsigned MVU_ID = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   mvu_apb_csr_if.slave apb,
   input  logic        mvu_done,
   output logic        start,
   output logic [28:0] cntdwn,
   output logic [8:0]  wbaseptr,
   output logic [14:0] ibaseptr,
   output logic [14:0] obaseptr,
   output logic [5:0]  wprec,
   output logic [5:0]  iprec,
   output logic [5:0]  oprec,
   output logic [4:0]  quant_msbidx,
   output logic [15:0] scaler_b
);

   localparam logic [11:0] A_WBASE  = 12'hf20;
   localparam logic [11:0] A_IBASE  = 12'hf21;
   localparam logic [11:0] A_OBASE  = 12'hf24;
   localparam logic [11:0] A_PREC   = 12'hf53;
   localparam logic [11:0] A_STATUS = 12'hf54;
   localparam logic [11:0] A_CMD    = 12'hf55;
   localparam logic [11:0] A_QMSB   = 12'hf56;
   localparam logic [11:0] A_SCALER = 12'hf57;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

   state_e      state_q;
   logic        wr_q;
   logic [14:0] addr_q;
   logic [31:0] wdata_q;
   logic [3:0]  strb_q;

   logic [8:0]  wbase_q;
   logic [14:0] ibase_q;
   logic [14:0] obase_q;
   logic [17:0] prec_q;
   logic [4:0]  qmsb_q;
   logic [15:0] scaler_q;
   logic [28:0] cntdwn_q;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        start_q;
   logic        pready_q;
   logic        pslverr_q;
   logic [31:0] prdata_q;

   logic [11:0] csr;
   logic        err_d;
   logic [31:0] rdata_d;
   logic        commit;

   assign csr = addr_q[11:0];

   // Decode the latched request into an error flag and read data.
   always_comb begin
      err_d   = 1'b0;
      rdata_d = '0;
      case (csr)
         A_WBASE:  rdata_d = {23'b0, wbase_q};
         A_IBASE:  rdata_d = {17'b0, ibase_q};
         A_OBASE:  rdata_d = {17'b0, obase_q};
         A_PREC:   rdata_d = {14'b0, prec_q};
         A_QMSB:   rdata_d = {27'b0, qmsb_q};
         A_SCALER: rdata_d = {16'b0, scaler_q};
         A_STATUS: begin
            rdata_d = {30'b0, done_q, busy_q};
            if (wr_q) err_d = 1'b1;
         end
         A_CMD:    if (!wr_q || busy_q) err_d = 1'b1;
         default:  err_d = 1'b1;
      endcase
      if (addr_q[14:12] != 3'(MVU_ID)) err_d = 1'b1;
      if (wr_q && strb_q != 4'hF)      err_d = 1'b1;
      if (err_d || wr_q)               rdata_d = '0;
   end

   assign commit = (state_q == S_WAIT) && !err_d;

   // Job status: mvu_done is applied after any commit so a done pulse wins
   // over the read-to-clear of STATUS in the same cycle.
   always_comb begin
      busy_d = busy_q;
      done_d = done_q;
      if (commit && wr_q && csr == A_CMD) begin
         busy_d = 1'b1;
         done_d = 1'b0;
      end else if (commit && !wr_q && csr == A_STATUS) begin
         done_d = 1'b0;
      end
      if (mvu_done && busy_q) begin
         busy_d = 1'b0;
         done_d = 1'b1;
      end
   end

   // Transfer FSM with registered bus response, register commits and start pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         wr_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         strb_q    <= '0;
         wbase_q   <= '0;
         ibase_q   <= '0;
         obase_q   <= '0;
         prec_q    <= '0;
         qmsb_q    <= '0;
         scaler_q  <= '0;
         cntdwn_q  <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         start_q   <= 1'b0;
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
         prdata_q  <= '0;
      end else begin
         busy_q  <= busy_d;
         done_q  <= done_d;
         start_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               pready_q  <= 1'b0;
               pslverr_q <= 1'b0;
               prdata_q  <= '0;
               if (apb.psel && apb.penable) begin
                  wr_q    <= apb.pwrite;
                  addr_q  <= apb.paddr;
                  wdata_q <= apb.pwdata;
                  strb_q  <= apb.pstrb;
                  state_q <= S_WAIT;
               end
            end
            S_WAIT: begin
               pready_q  <= 1'b1;
               pslverr_q <= err_d;
               prdata_q  <= rdata_d;
               state_q   <= S_RESP;
               if (commit && wr_q) begin
                  case (csr)
                     A_WBASE:  wbase_q  <= wdata_q[8:0];
                     A_IBASE:  ibase_q  <= wdata_q[14:0];
                     A_OBASE:  obase_q  <= wdata_q[14:0];
                     A_PREC:   prec_q   <= wdata_q[17:0];
                     A_QMSB:   qmsb_q   <= wdata_q[4:0];
                     A_SCALER: scaler_q <= wdata_q[15:0];
                     A_CMD: begin
                        cntdwn_q <= wdata_q[28:0];
                        start_q  <= 1'b1;
                     end
                     default: ;
                  endcase
               end
            end
            S_RESP: begin
               pready_q  <= 1'b0;
               pslverr_q <= 1'b0;
               prdata_q  <= '0;
               state_q   <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign apb.prdata  = prdata_q;
   assign apb.pready  = pready_q;
   assign apb.pslverr = pslverr_q;
   assign start        = start_q;
   assign cntdwn       = cntdwn_q;
   assign wbaseptr     = wbase_q;
   assign ibaseptr     = ibase_q;
   assign obaseptr     = obase_q;
   assign wprec        = prec_q[5:0];
   assign iprec        = prec_q[11:6];
   assign oprec        = prec_q[17:12];
   assign quant_msbidx = qmsb_q;
   assign scaler_b     = scaler_q;

endmodule

// File: tb/tb_mvu_apb_csr.sv
// Directed bench for mvu_apb_csr: register-map model plus per-cycle output checks.
module tb_mvu_apb_csr;

   localparam logic [2:0] MVU = 3'd0;

   logic        clk;
   logic        rst_n;
   logic        mvu_done;
   logic        start;
   logic [28:0] cntdwn;
   logic [8:0]  wbaseptr;
   logic [14:0] ibaseptr, obaseptr;
   logic [5:0]  wprec, iprec, oprec;
   logic [4:0]  quant_msbidx;
   logic [15:0] scaler_b;

   mvu_apb_csr_if apb ();

   mvu_apb_csr #(.MVU_ID(0)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .apb          (apb.slave),
      .mvu_done     (mvu_done),
      .start        (start),
      .cntdwn       (cntdwn),
      .wbaseptr     (wbaseptr),
      .ibaseptr     (ibaseptr),
      .obaseptr     (obaseptr),
      .wprec        (wprec),
      .iprec        (iprec),
      .oprec        (oprec),
      .quant_msbidx (quant_msbidx),
      .scaler_b     (scaler_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_tests = 0;
   int n_fail  = 0;

   // Model state: CSR contents (already masked), job status, expected start.
   logic [31:0] m_csr [0:4095];
   bit          m_busy, m_done, m_start;
   logic [28:0] m_cnt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] mask_of(input logic [11:0] csr);
      case (csr)
         12'hf20: return 32'h0000_01FF;
         12'hf21: return 32'h0000_7FFF;
         12'hf24: return 32'h0000_7FFF;
         12'hf53: return 32'h0003_FFFF;
         12'hf56: return 32'h0000_001F;
         12'hf57: return 32'h0000_FFFF;
         default: return 32'h0;
      endcase
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < 4096; i++) m_csr[i] = 32'h0;
      m_busy  = 1'b0;
      m_done  = 1'b0;
      m_start = 1'b0;
      m_cnt   = '0;
   endfunction

   function automatic void model_resp(input bit wr, input logic [14:0] addr,
                                      input logic [3:0] strb,
                                      output bit err, output logic [31:0] rdata);
      logic [11:0] csr;
      logic [2:0]  sel;
      bit          is_stat, is_cmd;
      csr     = addr[11:0];
      sel     = addr[14:12];
      is_stat = (csr == 12'hf54);
      is_cmd  = (csr == 12'hf55);
      err = 1'b0;
      if (sel != MVU)                                   err = 1'b1;
      if (mask_of(csr) == 32'h0 && !is_stat && !is_cmd) err = 1'b1;
      if (wr && is_stat)                                err = 1'b1;
      if (!wr && is_cmd)                                err = 1'b1;
      if (wr && strb != 4'hF)                           err = 1'b1;
      if (wr && is_cmd && m_busy)                       err = 1'b1;
      rdata = 32'h0;
      if (!err && !wr) rdata = is_stat ? {30'b0, m_done, m_busy} : m_csr[csr];
   endfunction

   function automatic void model_commit(input bit wr, input logic [14:0] addr,
                                        input logic [31:0] data, input bit err,
                                        input bit pulse);
      logic [11:0] csr;
      csr = addr[11:0];
      if (!err) begin
         if (wr && csr == 12'hf55) begin
            m_cnt   = data[28:0];
            m_busy  = 1'b1;
            m_done  = 1'b0;
            m_start = 1'b1;
         end else if (wr) begin
            m_csr[csr] = data & mask_of(csr);
         end else if (csr == 12'hf54) begin
            m_done = 1'b0;
         end
      end
      if (pulse && m_busy) begin
         m_busy = 1'b0;
         m_done = 1'b1;
      end
   endfunction

   // One APB transfer; pulse raises mvu_done in the WAIT cycle, drop releases psel early.
   task automatic xfer(input bit wr, input logic [14:0] addr, input logic [31:0] data,
                       input logic [3:0] strb, input bit pulse, input bit drop,
                       output logic [31:0] rd, output bit er);
      logic [31:0] exp_rd;
      bit          exp_err;
      int          n;
      bit          got;
      model_resp(wr, addr, strb, exp_err, exp_rd);
      @(posedge clk); #1;
      apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = wr;
      apb.paddr = addr; apb.pwdata = data; apb.pstrb = strb;
      @(posedge clk); #1;
      apb.penable = 1'b1;
      got = 1'b0;
      for (n = 1; n <= 8; n++) begin
         @(negedge clk);
         if (apb.pready) begin
            got = 1'b1;
            break;
         end
         if (n == 2 && drop)  begin apb.psel = 1'b0; apb.penable = 1'b0; end
         if (n == 2 && pulse) mvu_done = 1'b1;
      end
      mvu_done = 1'b0;
      chk("latency", 32'(n), 32'd3);
      rd = apb.prdata;
      er = apb.pslverr;
      if (got) begin
         chk("pslverr", 32'(er), 32'(exp_err));
         chk("prdata", rd, exp_rd);
         model_commit(wr, addr, data, exp_err, pulse);
      end
      @(posedge clk); #1;
      apb.psel = 1'b0; apb.penable = 1'b0;
      m_start = 1'b0;
   endtask

   task automatic done_pulse();
      @(negedge clk);
      mvu_done = 1'b1;
      @(negedge clk);
      mvu_done = 1'b0;
      if (m_busy) begin
         m_busy = 1'b0;
         m_done = 1'b1;
      end
   endtask

   // Every cycle: outputs must match the model and prdata stays 0 outside pready.
   always begin
      @(negedge clk);
      #1;
      chk("wbaseptr", 32'(wbaseptr), m_csr[12'hf20]);
      chk("ibaseptr", 32'(ibaseptr), m_csr[12'hf21]);
      chk("obaseptr", 32'(obaseptr), m_csr[12'hf24]);
      chk("prec", {14'b0, oprec, iprec, wprec}, m_csr[12'hf53]);
      chk("quant_msbidx", 32'(quant_msbidx), m_csr[12'hf56]);
      chk("scaler_b", 32'(scaler_b), m_csr[12'hf57]);
      chk("cntdwn", 32'(cntdwn), 32'(m_cnt));
      chk("start", 32'(start), 32'(m_start));
      if (!apb.pready) chk("prdata_idle", apb.prdata, 32'h0);
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   logic [31:0] rd;
   bit          er;

   initial begin
      model_reset();
      rst_n = 1'b0; mvu_done = 1'b0;
      apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
      apb.paddr = '0; apb.pwdata = '0; apb.pstrb = '0;
      repeat (3) @(negedge clk);
      chk("rst_pready", 32'(apb.pready), 32'h0);
      chk("rst_pslverr", 32'(apb.pslverr), 32'h0);
      chk("rst_cntdwn", 32'(cntdwn), 32'h0);
      rst_n = 1'b1;

      // Basic write/readback
      xfer(1, 15'h0f20, 32'h0000_01AB, 4'hF, 0, 0, rd, er);
      chk("wbase_wr_err", 32'(er), 32'h0);
      xfer(0, 15'h0f20, 32'h0, 4'hF, 0, 0, rd, er);
      chk("wbase_rd", rd, 32'h0000_01AB);
      chk("wbase_out", 32'(wbaseptr), 32'h1AB);

      xfer(1, 15'h0f53, 32'h0003_F0C2, 4'hF, 0, 0, rd, er);
      chk("wprec", 32'(wprec), 32'd2);
      chk("iprec", 32'(iprec), 32'd3);
      chk("oprec", 32'(oprec), 32'h3F);
      xfer(0, 15'h0f53, 32'h0, 4'hF, 0, 0, rd, er);
      chk("prec_rd", rd, 32'h0003_F0C2);

      // Unused bits read back as zero
      xfer(1, 15'h0f21, 32'hFFFF_FFFF, 4'hF, 0, 0, rd, er);
      xfer(0, 15'h0f21, 32'h0, 4'hF, 0, 0, rd, er);
      chk("ibase_rd", rd, 32'h0000_7FFF);
      xfer(1, 15'h0f24, 32'h1234_5678, 4'hF, 0, 0, rd, er);
      xfer(0, 15'h0f24, 32'h0, 4'hF, 0, 0, rd, er);
      chk("obase_rd", rd, 32'h0000_5678);
      xfer(1, 15'h0f56, 32'hFFFF_FFE5, 4'hF, 0, 0, rd, er);
      xfer(0, 15'h0f56, 32'h0, 4'hF, 0, 0, rd, er);
      chk("qmsb_rd", rd, 32'h0000_0005);
      xfer(1, 15'h0f57, 32'hDEAD_BEEF, 4'hF, 0, 0, rd, er);
      xfer(0, 15'h0f57, 32'h0, 4'hF, 0, 0, rd, er);
      chk("scaler_rd", rd, 32'h0000_BEEF);

      // Command / status flow
      xfer(1, 15'h0f55, 32'd100, 4'hF, 0, 0, rd, er);
      chk("cmd_err", 32'(er), 32'h0);
      chk("cmd_cntdwn", 32'(cntdwn), 32'd100);
      xfer(0, 15'h0f54, 32'h0, 4'hF, 0, 0, rd, er);
      chk("status_busy", rd, 32'h1);
      xfer(1, 15'h0f55, 32'd200, 4'hF, 0, 0, rd, er);
      chk("cmd_busy_err", 32'(er), 32'h1);
      chk("cmd_busy_cnt", 32'(cntdwn), 32'd100);
      xfer(0, 15'h0f55, 32'h0, 4'hF, 0, 0, rd, er);
      chk("cmd_read_err", 32'(er), 32'h1);
      xfer(1, 15'h0f54, 32'h3, 4'hF, 0, 0, rd, er);
      chk("status_wr_err", 32'(er), 32'h1);
      done_pulse();
      xfer(0, 15'h0f54, 32'h0, 4'hF, 0, 0, rd, er);
      chk("status_done", rd, 32'h2);
      xfer(0, 15'h0f54, 32'h0, 4'hF, 0, 0, rd, er);
      chk("status_clr", rd, 32'h0);

      // Error cases leave registers untouched
      xfer(1, 15'h1f20, 32'h0, 4'hF, 0, 0, rd, er);
      chk("badmvu_err", 32'(er), 32'h1);
      chk("badmvu_keep", 32'(wbaseptr), 32'h1AB);
      xfer(0, 15'h1f20, 32'h0, 4'hF, 0, 0, rd, er);
      chk("badmvu_rd", rd, 32'h0);
      xfer(0, 15'h0f99, 32'h0, 4'hF, 0, 0, rd, er);
      chk("unmapped_err", 32'(er), 32'h1);
      xfer(1, 15'h0f20, 32'h0, 4'h3, 0, 0, rd, er);
      chk("strb_err", 32'(er), 32'h1);
      chk("strb_keep", 32'(wbaseptr), 32'h1AB);

      // Done pulse while idle is ignored
      done_pulse();
      xfer(0, 15'h0f54, 32'h0, 4'hF, 0, 0, rd, er);
      chk("idle_done", rd, 32'h0);

      // Done in the WAIT cycle does not rescue a busy COMMAND write
      xfer(1, 15'h0f55, 32'd7, 4'hF, 0, 0, rd, er);
      xfer(1, 15'h0f55, 32'd9, 4'hF, 1, 0, rd, er);
      chk("late_done_err", 32'(er), 32'h1);
      chk("late_done_cnt", 32'(cntdwn), 32'd7);
      xfer(0, 15'h0f54, 32'h0, 4'hF, 0, 0, rd, er);
      chk("late_done_st", rd, 32'h2);

      // Done coincident with STATUS read: set wins over clear
      xfer(1, 15'h0f55, 32'd5, 4'hF, 0, 0, rd, er);
      xfer(0, 15'h0f54, 32'h0, 4'hF, 1, 0, rd, er);
      chk("coinc_rd", rd, 32'h1);
      xfer(0, 15'h0f54, 32'h0, 4'hF, 0, 0, rd, er);
      chk("coinc_after", rd, 32'h2);

      // psel released mid-transfer still completes
      xfer(1, 15'h0f56, 32'h0000_000A, 4'hF, 0, 1, rd, er);
      chk("drop_err", 32'(er), 32'h0);
      chk("drop_val", 32'(quant_msbidx), 32'h0A);

      // Reset during WAIT of a write discards it
      @(posedge clk); #1;
      apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b1;
      apb.paddr = 15'h0f57; apb.pwdata = 32'h55; apb.pstrb = 4'hF;
      @(posedge clk); #1;
      apb.penable = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("rst_mid_pready", 32'(apb.pready), 32'h0);
      chk("rst_mid_scaler", 32'(scaler_b), 32'h0);
      apb.psel = 1'b0; apb.penable = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      xfer(0, 15'h0f57, 32'h0, 4'hF, 0, 0, rd, er);
      chk("post_rst_rd", rd, 32'h0);
      chk("post_rst_err", 32'(er), 32'h0);

      @(negedge clk);
      #2;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
